// File: rtl/reorder_buffer_if.sv
// Reorder buffer interface: decoder issue port, common data bus, operand
// query port, and commit/flush outputs toward the regfile and fetch unit.
//
// Handshake: an issue is accepted on a rising clk edge when issue_valid=1 and
// rob_full=0; alloc_tag names the tag that accepted issue receives. The CDB,
// query and commit/flush paths have no backpressure: a CDB beat is taken on
// the edge it is valid, queries answer combinationally, and commit/flush
// outputs are one-cycle registered pulses.
interface reorder_buffer_if;
    // decoder issue port
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_is_branch;
    logic        issue_pred_taken;
    logic [3:0]  alloc_tag;
    logic        rob_full;

    // common data bus writeback
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        cdb_taken;
    logic [31:0] cdb_target;

    // operand forwarding queries
    logic [3:0]  query_tag1;
    logic [3:0]  query_tag2;
    logic        query_ready1;
    logic        query_ready2;
    logic [31:0] query_value1;
    logic [31:0] query_value2;

    // retirement and recovery
    logic [4:0]  commit_reg;
    logic [3:0]  commit_tag;
    logic [31:0] commit_value;
    logic        flush_out;
    logic [31:0] flush_pc;

    // pipeline side (decoder, execution units, regfile)
    modport master (
        output issue_valid, issue_rd, issue_is_branch, issue_pred_taken,
        input  alloc_tag, rob_full,
        output cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target,
        output query_tag1, query_tag2,
        input  query_ready1, query_ready2, query_value1, query_value2,
        input  commit_reg, commit_tag, commit_value, flush_out, flush_pc
    );

    // reorder buffer side
    modport slave (
        input  issue_valid, issue_rd, issue_is_branch, issue_pred_taken,
        output alloc_tag, rob_full,
        input  cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target,
        input  query_tag1, query_tag2,
        output query_ready1, query_ready2, query_value1, query_value2,
        output commit_reg, commit_tag, commit_value, flush_out, flush_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// 15-entry reorder buffer with in-order commit, CDB writeback, two operand
// forwarding query ports and branch mispredict recovery. Tags run 1..15;
// tag 0 means "no ROB tag", so storage slot 0 exists but is never allocated
// and therefore never reads as busy.
module reorder_buffer (
    input  logic             clk,
    input  logic             rst,
    reorder_buffer_if.slave  bus
);

    // per-entry state, indexed directly by tag (slot 0 stays idle)
    logic [15:0] r_busy;
    logic [15:0] r_ready;
    logic [15:0] r_is_branch;
    logic [15:0] r_pred_taken;
    logic [15:0] r_taken;
    logic [4:0]  r_rd     [16];
    logic [31:0] r_value  [16];
    logic [31:0] r_target [16];

    // queue control
    logic [3:0]  r_head;
    logic [3:0]  r_tail;
    logic [3:0]  r_count;
    logic        r_full;

    // registered retirement outputs
    logic [4:0]  r_commit_reg;
    logic [3:0]  r_commit_tag;
    logic [31:0] r_commit_value;
    logic        r_flush_out;
    logic [31:0] r_flush_pc;

    // decoded events for this edge
    logic        w_commit;
    logic        w_mispredict;
    logic        w_issue;
    logic        w_cdb_hit;
    logic [3:0]  w_count_next;

    // pointer increment that skips the reserved tag 0
    function automatic logic [3:0] f_next(input logic [3:0] p);
        return (p == 4'd15) ? 4'd1 : p + 4'd1;
    endfunction

    // Head commits only when its ready flag was set before this edge, so a
    // CDB beat to the head this cycle retires on the following edge.
    assign w_commit     = r_busy[r_head] & r_ready[r_head];
    assign w_mispredict = w_commit & r_is_branch[r_head]
                          & (r_taken[r_head] != r_pred_taken[r_head]);
    // Fullness is the registered flag, so a same-cycle commit does not
    // open a slot for this cycle's issue.
    assign w_issue      = bus.issue_valid & ~r_full;
    assign w_cdb_hit    = bus.cdb_valid & r_busy[bus.cdb_tag];
    assign w_count_next = r_count + (w_issue ? 4'd1 : 4'd0)
                                  - (w_commit ? 4'd1 : 4'd0);

    // entry storage: allocate at tail, write back from CDB, free at head
    always_ff @(posedge clk) begin
        if (rst || w_mispredict) begin
            r_busy       <= '0;
            r_ready      <= '0;
            r_is_branch  <= '0;
            r_pred_taken <= '0;
            r_taken      <= '0;
            for (int i = 0; i < 16; i++) begin
                r_rd[i]     <= '0;
                r_value[i]  <= '0;
                r_target[i] <= '0;
            end
        end else begin
            if (w_cdb_hit) begin
                r_value[bus.cdb_tag]  <= bus.cdb_value;
                r_taken[bus.cdb_tag]  <= bus.cdb_taken;
                r_target[bus.cdb_tag] <= bus.cdb_target;
                r_ready[bus.cdb_tag]  <= 1'b1;
            end
            // freeing after the CDB update keeps a freed slot not-ready
            if (w_commit) begin
                r_busy[r_head]  <= 1'b0;
                r_ready[r_head] <= 1'b0;
            end
            // tail is never busy when an issue is accepted, so this cannot
            // collide with the CDB or commit updates above
            if (w_issue) begin
                r_busy[r_tail]       <= 1'b1;
                r_ready[r_tail]      <= 1'b0;
                r_rd[r_tail]         <= bus.issue_rd;
                r_is_branch[r_tail]  <= bus.issue_is_branch;
                r_pred_taken[r_tail] <= bus.issue_pred_taken;
            end
        end
    end

    // pointers, occupancy and one-cycle commit/flush pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head         <= 4'd1;
            r_tail         <= 4'd1;
            r_count        <= 4'd0;
            r_full         <= 1'b0;
            r_commit_reg   <= '0;
            r_commit_tag   <= '0;
            r_commit_value <= '0;
            r_flush_out    <= 1'b0;
            r_flush_pc     <= '0;
        end else if (w_mispredict) begin
            // the branch itself retires; everything younger is squashed
            r_head         <= 4'd1;
            r_tail         <= 4'd1;
            r_count        <= 4'd0;
            r_full         <= 1'b0;
            r_commit_reg   <= '0;
            r_commit_tag   <= r_head;
            r_commit_value <= r_value[r_head];
            r_flush_out    <= 1'b1;
            r_flush_pc     <= r_target[r_head];
        end else begin
            r_commit_reg   <= '0;
            r_commit_tag   <= '0;
            r_commit_value <= '0;
            r_flush_out    <= 1'b0;
            r_flush_pc     <= '0;
            if (w_commit) begin
                // branches never write the register file
                r_commit_reg   <= r_is_branch[r_head] ? 5'd0 : r_rd[r_head];
                r_commit_tag   <= r_head;
                r_commit_value <= r_value[r_head];
                r_head         <= f_next(r_head);
            end
            if (w_issue) begin
                r_tail <= f_next(r_tail);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == 4'd15);
        end
    end

    // operand query 1: stored value, then same-cycle CDB bypass, else not ready
    always_comb begin
        bus.query_ready1 = 1'b0;
        bus.query_value1 = '0;
        if (r_busy[bus.query_tag1] && r_ready[bus.query_tag1]) begin
            bus.query_ready1 = 1'b1;
            bus.query_value1 = r_value[bus.query_tag1];
        end else if (r_busy[bus.query_tag1] && bus.cdb_valid
                     && (bus.cdb_tag == bus.query_tag1)) begin
            bus.query_ready1 = 1'b1;
            bus.query_value1 = bus.cdb_value;
        end
    end

    // operand query 2: same priority as query 1
    always_comb begin
        bus.query_ready2 = 1'b0;
        bus.query_value2 = '0;
        if (r_busy[bus.query_tag2] && r_ready[bus.query_tag2]) begin
            bus.query_ready2 = 1'b1;
            bus.query_value2 = r_value[bus.query_tag2];
        end else if (r_busy[bus.query_tag2] && bus.cdb_valid
                     && (bus.cdb_tag == bus.query_tag2)) begin
            bus.query_ready2 = 1'b1;
            bus.query_value2 = bus.cdb_value;
        end
    end

    assign bus.alloc_tag    = r_tail;
    assign bus.rob_full     = r_full;
    assign bus.commit_reg   = r_commit_reg;
    assign bus.commit_tag   = r_commit_tag;
    assign bus.commit_value = r_commit_value;
    assign bus.flush_out    = r_flush_out;
    assign bus.flush_pc     = r_flush_pc;

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL have: issue_valid input 1, decoder allocates an entry this cycle.
REQ-003 SHALL have: issue_rd input 5, destination register (0 = no register write).
REQ-004 SHALL have: issue_is_branch input 1, instruction is a conditional branch; issue_pred_taken input 1, predicted direction.
REQ-005 SHALL have: alloc_tag output 4, tag the next issue receives; rob_full output 1, no free entry.
REQ-006 SHALL have: cdb_valid input 1; cdb_tag input 4; cdb_value input 32; cdb_taken input 1, actual branch direction; cdb_target input 32, correct next PC for a branch.
REQ-007 SHALL have: query_tag1 and query_tag2 inputs 4; query_ready1 and query_ready2 outputs 1; query_value1 and query_value2 outputs 32, operand forwarding to decoder.
REQ-008 SHALL have: commit_reg output 5, register written by the regfile (0 = none); commit_tag output 4; commit_value output 32.
REQ-009 SHALL have: flush_out output 1, mispredict recovery pulse; flush_pc output 32, redirect target.

Function
REQ-010 SHALL hold 15 entries addressed by tag 1..15; tag 0 SHALL be reserved as "no ROB tag".
REQ-011 SHALL keep head and tail pointers that advance 15 -> 1 on wrap and never take the value 0.
REQ-012 SHALL keep an occupancy count 0..15; rob_full SHALL be 1 iff the count equals 15 (registered state).
REQ-013 SHALL drive alloc_tag combinationally equal to tail.
REQ-014 Issue: on an edge with issue_valid=1 and rob_full=0, the entry at tail SHALL be written busy=1, ready=0 with rd, is_branch and pred_taken, and tail SHALL advance by one.
REQ-015 An issue while rob_full=1 SHALL be ignored, even if a commit occurs in the same cycle.
REQ-016 Writeback: on an edge with cdb_valid=1 and the cdb_tag entry busy, that entry SHALL store value, taken and target and set ready=1.
REQ-017 A CDB write to a non-busy entry or to tag 0 SHALL be ignored.
REQ-018 Commit: on an edge where the head entry is busy and ready (flag already set before that edge), the entry SHALL be freed and head SHALL advance; at most one commit SHALL occur per cycle.
REQ-019 On a commit, commit_reg, commit_tag and commit_value SHALL be registered and valid for exactly one cycle after the commit edge, then return to 0.
REQ-020 A committing branch SHALL drive commit_reg=0.
REQ-021 Mispredict: a committing branch with taken != pred_taken SHALL set flush_out=1 and flush_pc=target for one cycle.
REQ-022 On the same mispredict edge, every entry SHALL be cleared and head=tail=1, count=0.
REQ-023 Issue and CDB inputs on the mispredict edge SHALL be discarded.
REQ-024 A correctly predicted branch SHALL commit with flush_out=0.
REQ-025 Simultaneous issue and commit SHALL leave the count unchanged; simultaneous CDB to the head entry SHALL not commit until the following edge.
REQ-026 Query (combinational): query_readyN=1 and query_valueN=stored value when the tagged entry is busy and ready.
REQ-027 Query bypass: otherwise query_readyN=1 and query_valueN=cdb_value when cdb_valid=1 and cdb_tag equals the tagged entry, provided that entry is busy.
REQ-028 Query default: otherwise query_readyN=0 and query_valueN=0; a query of tag 0 SHALL return ready 0.

Reset
REQ-029 While rst=1 at an edge, all entries SHALL be cleared and head=tail=1, count=0, rob_full=0, alloc_tag=1, commit_reg=0, commit_tag=0, commit_value=0, flush_out=0, flush_pc=0.
REQ-030 Reset SHALL override any simultaneous issue, CDB or commit.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight entries without emitting a commit.

Verification
REQ-032 Issue rd=5 (tag 1); next cycle CDB tag1 value 0x1234 -> two edges later commit_reg=5, commit_tag=1, commit_value=0x1234 for one cycle.
REQ-033 Issue tags 1,2; CDB tag2 first, then tag1 -> commits occur in order tag1 then tag2, on consecutive cycles.
REQ-034 Issue 15 entries -> rob_full=1; a 16th issue is ignored; commit head and issue -> new alloc_tag wraps to 1 after tag 15.
REQ-035 Branch tag 3 with pred_taken=0, CDB taken=1 target 0x100 with tags 4,5 pending -> at commit flush_out=1, flush_pc=0x100, then alloc_tag=1, rob_full=0, no commits for tags 4,5.
REQ-036 Query tag 2 while CDB broadcasts tag 2 value 0xAB -> query_ready=1, query_value=0xAB the same cycle; query tag 0 -> ready 0.
REQ-037 Assert rst with 6 entries busy -> next cycle count 0, alloc_tag=1, all commit outputs 0, no commit emitted.
